// File: rtl/money_key_gen_pkg.sv
// Shared definitions for the coin-key debouncer: state encodings and debounce timing.
package money_key_gen_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned COIN_W = 2;

  // 20 ms at 50 MHz, minus one
  localparam logic [CNT_W-1:0] CNT_MAX_20MS = 20'd999_999;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    FILTER_DN = 4'b0010,
    DOWN      = 4'b0100,
    FILTER_UP = 4'b1000
  } state_t;

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for an active-low key; resets to the released level (1).
module key_sync2
  import money_key_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/money_key_gen.sv
// Debounces the coin key into a single-cycle po_money pulse and keeps a modulo coin count.
module money_key_gen
  import money_key_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX       = CNT_MAX_20MS,
  parameter int unsigned      COIN_PER_COLA = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_in,
  output logic              po_money,
  output logic [COIN_W-1:0] po_money_cnt,
  output logic              po_key_state
);

  localparam logic [COIN_W-1:0] COIN_LAST = COIN_W'(COIN_PER_COLA - 1);

  logic              key_s2;
  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              money_nxt;
  logic              key_state_nxt;
  logic [COIN_W-1:0] coin_nxt;

  key_sync2 u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_in),
    .q     (key_s2)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      po_money     <= 1'b0;
      po_money_cnt <= '0;
      po_key_state <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      po_money     <= money_nxt;
      po_money_cnt <= coin_nxt;
      po_key_state <= key_state_nxt;
    end
  end

  // Next-state, filter counter and registered-output inputs
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    money_nxt     = 1'b0;
    key_state_nxt = po_key_state;
    coin_nxt      = po_money_cnt;

    case (state)
      IDLE: begin
        cnt_nxt       = '0;
        key_state_nxt = 1'b1;
        if (!key_s2) state_nxt = FILTER_DN;
      end
      FILTER_DN: begin
        if (key_s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt     = DOWN;
          cnt_nxt       = '0;
          money_nxt     = 1'b1;
          key_state_nxt = 1'b0;
          coin_nxt      = (po_money_cnt == COIN_LAST) ? '0 : po_money_cnt + COIN_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        cnt_nxt       = '0;
        key_state_nxt = 1'b0;
        if (key_s2) state_nxt = FILTER_UP;
      end
      FILTER_UP: begin
        if (!key_s2) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          key_state_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        key_state_nxt = 1'b1;
      end
    endcase
  end

endmodule
